// File: rtl/z80_uart_port.sv
// z80_uart_port: Z80 I/O-mapped 8N1 serial port (data + status registers).
//
// Ports:
//   clk      system / Z80 clock
//   reset    asynchronous active-low reset
//   iorq     Z80 /IORQ (active low), asynchronous to clk
//   rd, wr   Z80 /RD, /WR (active low), asynchronous to clk
//   A        Z80 address A[7:0]; assumed stable for the whole bus cycle
//   d_in     CPU data bus, input side
//   d_out    read data toward the CPU (0 when not being read)
//   d_oe     high while the top level must drive D with d_out
//   txd      serial transmit, idle high
//   rxd      serial receive, asynchronous
//   irq      high while a received byte is waiting (rx_full)
//   fsm_dbg  {tx_state, rx_state} for checkers and debug
//
// Status register: {4'b0, frame_err, overrun, ~hold_full, rx_full}.
//
// Bus handshake: there is no valid/ready pair here. A write is accepted once,
// on the first synchronised clk of /IORQ=/WR=0 at DATA_PORT, and is never
// back-pressured (a pending holding byte is silently replaced). A read is
// "consumed" on the synchronised rising edge of (/IORQ | /RD) at a matching
// port; that is when read side effects (flag clears) take place.
module z80_uart_port #(
  parameter int          CLK_DIV   = 16,
  parameter logic [7:0]  DATA_PORT = 8'hEF,
  parameter logic [7:0]  STAT_PORT = 8'hEE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] A,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       txd,
  input  logic       rxd,
  output logic       irq,
  output logic [3:0] fsm_dbg
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- synchronisers and bus events ----------------
  logic [1:0] iorq_sync, rd_sync, wr_sync, rxd_sync;
  logic       iorq_s, rd_s, wr_s, rxd_s;
  logic       wr_act, wr_act_q, bus_idle, bus_idle_q, rxd_q;
  logic       hit_data, hit_stat;
  logic       wr_ev, rd_end_data, rd_end_stat;

  assign iorq_s   = iorq_sync[1];
  assign rd_s     = rd_sync[1];
  assign wr_s     = wr_sync[1];
  assign rxd_s    = rxd_sync[1];
  assign hit_data = (A == DATA_PORT);
  assign hit_stat = (A == STAT_PORT);
  assign wr_act   = ~iorq_s & ~wr_s & hit_data;
  assign bus_idle = iorq_s | rd_s;

  assign wr_ev       = wr_act & ~wr_act_q;
  // A write cycle keeps /RD high, so (iorq|rd) only rises at the end of a read.
  assign rd_end_data = bus_idle & ~bus_idle_q & hit_data;
  assign rd_end_stat = bus_idle & ~bus_idle_q & hit_stat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iorq_sync  <= 2'b11;
      rd_sync    <= 2'b11;
      wr_sync    <= 2'b11;
      rxd_sync   <= 2'b11;
      wr_act_q   <= 1'b0;
      bus_idle_q <= 1'b1;
      rxd_q      <= 1'b1;
    end else begin
      iorq_sync  <= {iorq_sync[0], iorq};
      rd_sync    <= {rd_sync[0], rd};
      wr_sync    <= {wr_sync[0], wr};
      rxd_sync   <= {rxd_sync[0], rxd};
      wr_act_q   <= wr_act;
      bus_idle_q <= bus_idle;
      rxd_q      <= rxd_s;
    end
  end

  // ---------------- registers ----------------
  logic [7:0] hold_reg, tx_shift, rx_shift, rx_buf;
  logic       hold_full, rx_full, overrun, frame_err;

  // ---------------- read path ----------------
  always_comb begin
    d_oe  = reset & ~iorq & ~rd & (hit_data | hit_stat);
    d_out = 8'h00;
    if (d_oe) begin
      if (hit_data) d_out = rx_buf;
      else          d_out = {4'b0, frame_err, overrun, ~hold_full, rx_full};
    end
  end

  assign irq = rx_full;

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_next;
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_bit;
  logic          tx_tick, tx_load;

  assign tx_tick = (tx_timer == T_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE:  if (hold_full) begin
                  tx_load = 1'b1;
                  tx_next = TX_START;
                end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) begin
                  // Back-to-back frames skip IDLE entirely.
                  if (hold_full) begin
                    tx_load = 1'b1;
                    tx_next = TX_START;
                  end else begin
                    tx_next = TX_IDLE;
                  end
                end
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_timer  <= '0;
      tx_bit    <= 3'd0;
      tx_shift  <= 8'h00;
      hold_reg  <= 8'h00;
      hold_full <= 1'b0;
    end else begin
      if (tx_state == TX_IDLE || tx_next != tx_state || tx_tick) tx_timer <= '0;
      else                                                       tx_timer <= tx_timer + TW'(1);
      if (tx_state != TX_DATA) tx_bit <= 3'd0;
      else if (tx_tick)        tx_bit <= tx_bit + 3'd1;
      if (tx_load)                          tx_shift <= hold_reg;
      else if (tx_state == TX_DATA && tx_tick) tx_shift <= {1'b0, tx_shift[7:1]};
      // The load reads the old holding byte; a same-cycle write refills it.
      if (tx_load) hold_full <= 1'b0;
      if (wr_ev) begin
        hold_reg  <= d_in;
        hold_full <= 1'b1;
      end
    end
  end

  // Decoded from state so reset returns the line high without waiting on clk.
  always_comb begin
    case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_shift[0];
      default:  txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_next;
  logic [TW-1:0] rx_timer;
  logic [2:0]    rx_bit;
  logic          rx_tick, rx_half, rx_done;

  assign rx_tick = (rx_timer == T_LAST);
  assign rx_half = (rx_timer == T_HALF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rxd_q && !rxd_s) rx_next = RX_START;
      // Mid-start re-check; from here on every sample is mid-bit.
      RX_START: if (rx_half) rx_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) begin
                  rx_done = 1'b1;
                  rx_next = RX_IDLE;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_timer  <= '0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'h00;
      rx_buf    <= 8'h00;
      rx_full   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_next != rx_state || rx_tick) rx_timer <= '0;
      else                                                       rx_timer <= rx_timer + TW'(1);
      if (rx_state != RX_DATA) rx_bit <= 3'd0;
      else if (rx_tick)        rx_bit <= rx_bit + 3'd1;
      if (rx_state == RX_DATA && rx_tick) rx_shift <= {rxd_s, rx_shift[7:1]};
      // Clears first so that a same-cycle set takes priority.
      if (rd_end_data) rx_full <= 1'b0;
      if (rd_end_stat) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_done) begin
        rx_buf  <= rx_shift;
        rx_full <= 1'b1;
        if (rx_full) overrun   <= 1'b1;
        if (!rxd_s)  frame_err <= 1'b1;
      end
    end
  end

  assign fsm_dbg = {tx_state, rx_state};

endmodule

// File: tb/tb_z80_uart_port.sv
module tb_z80_uart_port;

  localparam int         DIV = 4;
  localparam logic [7:0] EF  = 8'hEF;
  localparam logic [7:0] EE  = 8'hEE;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       iorq  = 1'b1;
  logic       rd    = 1'b1;
  logic       wr    = 1'b1;
  logic [7:0] a     = 8'h00;
  logic [7:0] d_in  = 8'h00;
  logic       rxd   = 1'b1;
  logic [7:0] d_out;
  logic       d_oe, txd, irq;
  logic [3:0] fsm_dbg;

  always #5 clk = ~clk;

  z80_uart_port #(.CLK_DIV(DIV), .DATA_PORT(EF), .STAT_PORT(EE)) dut (
    .clk(clk), .reset(rst_n), .iorq(iorq), .rd(rd), .wr(wr), .A(a),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .txd(txd), .rxd(rxd),
    .irq(irq), .fsm_dbg(fsm_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];     // expected txd level, one entry per clk
  logic [7:0] txd_log[$];   // observed txd level, one entry per clk
  logic       tx_rec = 1'b0;

  // Receiver-side register model, in terms of frames and reads.
  logic       m_full, m_ov, m_fe;
  logic [7:0] m_buf;

  always @(posedge clk) begin
    #1;
    if (tx_rec) txd_log.push_back({7'h0, txd});
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_stat();
    return {4'b0, m_fe, m_ov, 1'b1, m_full};
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_buf = 8'h00;
  endtask

  // A frame on the wire: start 0, eight data bits LSB first, stop 1.
  task automatic push_frame(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      repeat (DIV) exp_q.push_back({7'h0, bits[i]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    a = addr; d_in = data;
    iorq = 1'b0; wr = 1'b0;
    tick(3);
    iorq = 1'b1; wr = 1'b1;
    tick(4);
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
    a = addr;
    iorq = 1'b0; rd = 1'b0;
    tick(3);
    check("d_oe_read", {7'h0, d_oe}, 8'h01);
    data = d_out;
    iorq = 1'b1; rd = 1'b1;
    tick(4);
    check("d_oe_idle", {7'h0, d_oe}, 8'h00);
  endtask

  task automatic read_stat(input string tag);
    logic [7:0] v;
    io_read(EE, v);
    check(tag, v, exp_stat());
    m_ov = 1'b0; m_fe = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [7:0] v;
    io_read(EF, v);
    check(tag, v, m_buf);
    m_full = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(DIV);
    end
    rxd = stop;
    tick(DIV);
    rxd = 1'b1;
    tick(4);
    if (!stop) m_fe = 1'b1;
    if (m_full) m_ov = 1'b1;
    m_full = 1'b1;
    m_buf  = b;
  endtask

  // Line must match exp_q from the first low level onward, then stay high.
  task automatic check_tx_log(input string tag);
    int         start;
    logic [7:0] e;
    start = -1;
    foreach (txd_log[i])
      if (start < 0 && txd_log[i] == 8'h00) start = i;
    check({tag, "_found"}, (start >= 0) ? 8'h01 : 8'h00, 8'h01);
    if (start >= 0) begin
      check({tag, "_len"}, (txd_log.size() - start >= exp_q.size()) ? 8'h01 : 8'h00, 8'h01);
      for (int i = 0; i < txd_log.size() - start; i++) begin
        e = (i < exp_q.size()) ? exp_q[i] : 8'h01;
        check($sformatf("%s_c%0d", tag, i), txd_log[start + i], e);
      end
    end
    txd_log.delete();
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] b;
    logic       stop;
    int         found;

    model_reset();

    // Reset held: bus activity and rxd noise must not disturb outputs.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (i < 4) begin
        iorq = 1'b0; rd = 1'b0; wr = 1'b1;
        a = (i % 2 == 0) ? EE : EF;
      end else begin
        iorq = 1'($urandom_range(0, 1));
        rd   = 1'($urandom_range(0, 1));
        wr   = 1'($urandom_range(0, 1));
        a    = 8'($urandom_range(0, 255));
      end
      d_in = 8'($urandom_range(0, 255));
      rxd  = 1'($urandom_range(0, 1));
      #3;
      check("rst_txd",   {7'h0, txd},  8'h01);
      check("rst_irq",   {7'h0, irq},  8'h00);
      check("rst_d_oe",  {7'h0, d_oe}, 8'h00);
      check("rst_d_out", d_out,        8'h00);
    end
    iorq = 1'b1; rd = 1'b1; wr = 1'b1; rxd = 1'b1; a = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    read_stat("stat_after_reset");

    // Single transmit.
    push_frame(8'hA5);
    tx_rec = 1'b1;
    io_write(EF, 8'hA5);
    tick(50);
    tx_rec = 1'b0;
    check_tx_log("tx_a5");
    read_stat("stat_after_tx");

    // Back-to-back: second byte written while the first is on the wire.
    push_frame(8'h55);
    push_frame(8'h0F);
    tx_rec = 1'b1;
    io_write(EF, 8'h55);
    tick(6);
    io_write(EF, 8'h0F);
    io_read(EE, b);
    check("stat_hold_full", b, {exp_stat()} & 8'hFD);
    tick(70);
    tx_rec = 1'b0;
    check_tx_log("tx_b2b");
    read_stat("stat_after_b2b");

    // Random transmit bytes.
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom_range(0, 255));
      push_frame(b);
      tx_rec = 1'b1;
      io_write(EF, b);
      tick(50);
      tx_rec = 1'b0;
      check_tx_log($sformatf("tx_rand%0d", k));
    end

    // Single receive.
    send_frame(8'h3C, 1'b1);
    check("rx_irq_set", {7'h0, irq}, {7'h0, m_full});
    read_stat("rx_stat_full");
    read_data("rx_data_3c");
    check("rx_irq_clr", {7'h0, irq}, {7'h0, m_full});
    read_stat("rx_stat_empty");

    // Overrun plus framing error, then status clear.
    send_frame(8'h81, 1'b1);
    send_frame(8'h7E, 1'b0);
    read_stat("ovr_fe_stat");
    read_stat("ovr_fe_cleared");
    read_data("ovr_data_7e");
    read_stat("ovr_final");

    // One-clk glitch on rxd must not start a reception.
    rxd = 1'b0;
    tick(DIV / 4);
    rxd = 1'b1;
    tick(50);
    check("glitch_irq", {7'h0, irq}, {7'h0, m_full});
    read_stat("glitch_stat");
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    read_data("post_glitch_data");

    // Random frames with random reads in between.
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      check($sformatf("rand_irq%0d", k), {7'h0, irq}, {7'h0, m_full});
      case ($urandom_range(0, 2))
        0: read_data($sformatf("rand_data%0d", k));
        1: read_stat($sformatf("rand_stat%0d", k));
        default: ;
      endcase
    end
    read_stat("rand_final_stat");
    read_data("rand_final_data");

    // Reset in the middle of data bit 3 of an all-zero byte.
    io_write(EF, 8'h00);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (txd == 1'b0) found = 1;
      else tick(1);
    end
    check("abort_start_found", 8'(found), 8'h01);
    tick(4 * DIV + 1);
    check("abort_bit3_low", {7'h0, txd}, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_txd_high", {7'h0, txd}, 8'h01);
    check("abort_irq_low",  {7'h0, irq}, 8'h00);
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tx_rec = 1'b1;
    tick(45);
    tx_rec = 1'b0;
    foreach (txd_log[i]) check($sformatf("abort_idle%0d", i), txd_log[i], 8'h01);
    txd_log.delete();
    read_stat("abort_stat");
    read_data("abort_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
